decade_extender: RTL and testbench

DECADE_EXTENDER -- requirements
Module: decade_extender

---
 rtl/decade_extender_pkg.sv | 22 ++
 rtl/decade_extender_if.sv | 38 +++
 rtl/decade_extender_bcd_step.sv | 29 ++
 rtl/decade_extender.sv | 134 +++++++++++++
 tb/tb_decade_extender.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/decade_extender_pkg.sv
// Shared types and constants for the decade extender.
// Contents:
//   digit_t  - 4-bit BCD digit
//   state_t  - tracking FSM state (UNPRIMED, TRACK)
//   BCD_MAX  - largest legal BCD digit value
//   is_bcd() - true when a digit is a legal BCD code
package decade_extender_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } state_t;

  localparam digit_t BCD_MAX = 4'd9;

  function automatic logic is_bcd(digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/decade_extender_if.sv
// Bus bundle between the ones-counter side and the decade extender.
// Signals:
//   Clear     - synchronous clear of tens, flags and tracking state
//   Enable    - sample Ones this cycle
//   Ones      - BCD state of the upstream modulo-10 counter
//   Tens      - registered tens digit, 0..TENS_MAX
//   OnesOut   - registered copy of the last accepted Ones
//   Carry     - one-cycle pulse on a 9->0 ones wrap
//   Borrow    - one-cycle pulse on a 0->9 ones wrap
//   Overflow  - sticky, Tens wrapped TENS_MAX->0
//   Underflow - sticky, Tens wrapped 0->TENS_MAX
//   CodeErr   - sticky, a sampled Ones was not a legal BCD code
// master drives Clear/Enable/Ones; slave (the extender) drives the rest.
interface decade_extender_if;
  import decade_extender_pkg::*;

  logic   Clear;
  logic   Enable;
  digit_t Ones;
  digit_t Tens;
  digit_t OnesOut;
  logic   Carry;
  logic   Borrow;
  logic   Overflow;
  logic   Underflow;
  logic   CodeErr;

  modport master (
    output Clear, Enable, Ones,
    input  Tens, OnesOut, Carry, Borrow, Overflow, Underflow, CodeErr
  );

  modport slave (
    input  Clear, Enable, Ones,
    output Tens, OnesOut, Carry, Borrow, Overflow, Underflow, CodeErr
  );

endinterface

// File: rtl/decade_extender_bcd_step.sv
// bcd_step: combinational +1/-1 of a digit that wraps against a limit.
// Ports:
//   value  - current digit
//   limit  - highest value the digit may hold
//   up     - 1 = increment, 0 = decrement
//   result - stepped digit, always within 0..limit
//   wrap   - 1 when this step wrapped (limit->0 going up, 0->limit going down)
module bcd_step
  import decade_extender_pkg::*;
(
  input  digit_t value,
  input  digit_t limit,
  input  logic   up,
  output digit_t result,
  output logic   wrap
);

  always_comb begin
    if (up) begin
      // >= rather than == so an out-of-range value still lands back on 0
      wrap   = (value >= limit);
      result = wrap ? 4'd0 : digit_t'(value + 4'd1);
    end else begin
      wrap   = (value == 4'd0);
      result = wrap ? limit : digit_t'(value - 4'd1);
    end
  end

endmodule

// File: rtl/decade_extender.sv
// decade_extender: watches the ones digit of an upstream modulo-10 counter
// and maintains a tens digit, detecting 9->0 (carry) and 0->9 (borrow)
// wraps of the ones digit between consecutive accepted samples.
// Ports:
//   Clock  - rising-edge clock
//   Resetn - asynchronous active-low reset
//   bus    - decade_extender_if.slave (see interface for signal list)
// Parameter:
//   TENS_MAX - highest tens value, legal 1..9
// All outputs come straight from registers; a sample accepted at one edge
// is reflected on the outputs right after that edge.
module decade_extender
  import decade_extender_pkg::*;
#(
  parameter int unsigned TENS_MAX = 9
) (
  input  logic               Clock,
  input  logic               Resetn,
  decade_extender_if.slave   bus
);

  localparam digit_t TENS_LIMIT = digit_t'(TENS_MAX);

  state_t state_reg, state_next;
  digit_t prev_reg,  prev_next;
  digit_t tens_reg,  tens_next;
  digit_t ones_reg,  ones_next;
  logic   carry_reg, carry_next;
  logic   borrow_reg, borrow_next;
  logic   ovf_reg,   ovf_next;
  logic   unf_reg,   unf_next;
  logic   cerr_reg,  cerr_next;

  logic   sample_legal;
  logic   is_carry;
  logic   is_borrow;
  digit_t tens_stepped;
  logic   tens_wrap;

  // Wraps are only meaningful once a reference sample exists (TRACK).
  assign sample_legal = is_bcd(bus.Ones);
  assign is_carry  = (state_reg == TRACK) && bus.Enable && sample_legal &&
                     (prev_reg == BCD_MAX) && (bus.Ones == 4'd0);
  assign is_borrow = (state_reg == TRACK) && bus.Enable && sample_legal &&
                     (prev_reg == 4'd0) && (bus.Ones == BCD_MAX);

  // Direction follows the event; when neither fires the result is unused.
  bcd_step u_tens_step (
    .value  (tens_reg),
    .limit  (TENS_LIMIT),
    .up     (is_carry),
    .result (tens_stepped),
    .wrap   (tens_wrap)
  );

  // State and datapath registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg  <= UNPRIMED;
      prev_reg   <= '0;
      tens_reg   <= '0;
      ones_reg   <= '0;
      carry_reg  <= 1'b0;
      borrow_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      cerr_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      prev_reg   <= prev_next;
      tens_reg   <= tens_next;
      ones_reg   <= ones_next;
      carry_reg  <= carry_next;
      borrow_reg <= borrow_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
      cerr_reg   <= cerr_next;
    end
  end

  // Next-state logic: an illegal code never moves the FSM.
  always_comb begin
    state_next = state_reg;
    if (bus.Clear) begin
      state_next = UNPRIMED;
    end else if (bus.Enable && sample_legal) begin
      state_next = TRACK;
    end
  end

  // Output / datapath logic
  always_comb begin
    prev_next   = prev_reg;
    tens_next   = tens_reg;
    ones_next   = ones_reg;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    ovf_next    = ovf_reg;
    unf_next    = unf_reg;
    cerr_next   = cerr_reg;
    if (bus.Clear) begin
      // Clear wins over any wrap sampled in the same cycle
      prev_next = '0;
      tens_next = '0;
      ones_next = '0;
      ovf_next  = 1'b0;
      unf_next  = 1'b0;
      cerr_next = 1'b0;
    end else if (bus.Enable) begin
      if (!sample_legal) begin
        cerr_next = 1'b1;
      end else begin
        prev_next = bus.Ones;
        ones_next = bus.Ones;
        if (is_carry || is_borrow) begin
          tens_next   = tens_stepped;
          carry_next  = is_carry;
          borrow_next = is_borrow;
          ovf_next    = ovf_reg | (is_carry  & tens_wrap);
          unf_next    = unf_reg | (is_borrow & tens_wrap);
        end
      end
    end
  end

  assign bus.Tens      = tens_reg;
  assign bus.OnesOut   = ones_reg;
  assign bus.Carry     = carry_reg;
  assign bus.Borrow    = borrow_reg;
  assign bus.Overflow  = ovf_reg;
  assign bus.Underflow = unf_reg;
  assign bus.CodeErr   = cerr_reg;

endmodule

// File: tb/tb_decade_extender.sv
// Testbench for decade_extender: directed scenarios plus a randomized phase,
// checked by a scoreboard fed from a behavioural model of the tens counter.
module tb_decade_extender;
  import decade_extender_pkg::*;

  localparam int TM = 9;

  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  decade_extender_if bus();

  decade_extender #(.TENS_MAX(TM)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  typedef struct {
    int tens;
    int ones_out;
    int carry;
    int borrow;
    int ovf;
    int unf;
    int cerr;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int txn        = 0;

  // Behavioural model: a decimal count position as tens digit + last ones
  int m_tens, m_ones_out, m_prev;
  bit m_primed, m_ovf, m_unf, m_cerr;

  task automatic model_reset();
    m_tens = 0; m_ones_out = 0; m_prev = 0;
    m_primed = 0; m_ovf = 0; m_unf = 0; m_cerr = 0;
  endtask

  task automatic model_step(input bit clr, input bit en, input int ones);
    exp_t e;
    e.carry = 0;
    e.borrow = 0;
    if (clr) begin
      model_reset();
    end else if (en) begin
      if (ones > 9) begin
        m_cerr = 1;
      end else begin
        if (m_primed && m_prev == 9 && ones == 0) begin
          e.carry = 1;
          m_tens = (m_tens + 1) % (TM + 1);
          if (m_tens == 0) m_ovf = 1;
        end else if (m_primed && m_prev == 0 && ones == 9) begin
          e.borrow = 1;
          m_tens = (m_tens + TM) % (TM + 1);
          if (m_tens == TM) m_unf = 1;
        end
        m_primed = 1;
        m_prev = ones;
        m_ones_out = ones;
      end
    end
    e.tens = m_tens;
    e.ones_out = m_ones_out;
    e.ovf = int'(m_ovf);
    e.unf = int'(m_unf);
    e.cerr = int'(m_cerr);
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Inputs change on the falling edge; the sampling edge follows.
  task automatic drive(input bit clr, input bit en, input int ones);
    @(negedge Clock);
    bus.Clear  = clr;
    bus.Enable = en;
    bus.Ones   = 4'(ones);
    model_step(clr, en, ones);
  endtask

  // Wait for the edge that samples the last drive, then look at outputs.
  task automatic settle();
    @(posedge Clock);
    #3;
  endtask

  // Monitor: every edge with a pending expectation is one transaction.
  always @(posedge Clock) begin
    exp_t e;
    #2;
    if (Resetn && sb.size() > 0) begin
      e = sb.pop_front();
      txn++;
      compared++;
      if (int'(bus.Tens) != e.tens || int'(bus.OnesOut) != e.ones_out ||
          int'(bus.Carry) != e.carry || int'(bus.Borrow) != e.borrow ||
          int'(bus.Overflow) != e.ovf || int'(bus.Underflow) != e.unf ||
          int'(bus.CodeErr) != e.cerr) begin
        mismatched++;
        $display("FAIL txn %0d: got T=%0d O=%0d C=%0d B=%0d OV=%0d UN=%0d CE=%0d, required T=%0d O=%0d C=%0d B=%0d OV=%0d UN=%0d CE=%0d",
                 txn, bus.Tens, bus.OnesOut, bus.Carry, bus.Borrow, bus.Overflow,
                 bus.Underflow, bus.CodeErr, e.tens, e.ones_out, e.carry,
                 e.borrow, e.ovf, e.unf, e.cerr);
      end else begin
        $display("txn %0d ok: T=%0d O=%0d C=%0d B=%0d OV=%0d UN=%0d CE=%0d",
                 txn, e.tens, e.ones_out, e.carry, e.borrow, e.ovf, e.unf, e.cerr);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_tens"},    int'(bus.Tens), 0);
    check({tag, "_onesout"}, int'(bus.OnesOut), 0);
    check({tag, "_carry"},   int'(bus.Carry), 0);
    check({tag, "_borrow"},  int'(bus.Borrow), 0);
    check({tag, "_ovf"},     int'(bus.Overflow), 0);
    check({tag, "_unf"},     int'(bus.Underflow), 0);
    check({tag, "_cerr"},    int'(bus.CodeErr), 0);
  endtask

  initial begin
    int last;
    int o;
    bit clr, en;

    Resetn = 1'b0;
    bus.Clear = 1'b0;
    bus.Enable = 1'b0;
    bus.Ones = 4'd0;
    model_reset();
    repeat (2) @(negedge Clock);
    check_all_zero("reset");
    Resetn = 1'b1;

    // Wrap-up: 7,8,9,0,1 -> one carry after the 0, Tens 1, OnesOut 1
    drive(0, 1, 7); drive(0, 1, 8); drive(0, 1, 9);
    drive(0, 1, 0);
    settle();
    check("wrapup_carry", int'(bus.Carry), 1);
    drive(0, 1, 1);
    settle();
    check("wrapup_tens", int'(bus.Tens), 1);
    check("wrapup_onesout", int'(bus.OnesOut), 1);
    check("wrapup_carry_gone", int'(bus.Carry), 0);

    // Wrap-down from Tens=0: 1,0,9 -> borrow, Tens 9, Underflow
    drive(1, 0, 0);
    drive(0, 1, 1); drive(0, 1, 0); drive(0, 1, 9);
    settle();
    check("wrapdn_borrow", int'(bus.Borrow), 1);
    check("wrapdn_tens", int'(bus.Tens), 9);
    check("wrapdn_unf", int'(bus.Underflow), 1);

    // Overflow: 100 up-counts from 0
    drive(1, 0, 0);
    drive(0, 1, 0);
    for (int i = 1; i <= 100; i++) drive(0, 1, i % 10);
    settle();
    check("ovf_tens", int'(bus.Tens), 0);
    check("ovf_flag", int'(bus.Overflow), 1);
    check("ovf_unf", int'(bus.Underflow), 0);

    // Illegal code between 9 and 0: prev stays 9 so the 0 still carries
    drive(1, 0, 0);
    drive(0, 1, 8); drive(0, 1, 9); drive(0, 1, 12);
    settle();
    check("cerr_flag", int'(bus.CodeErr), 1);
    check("cerr_onesout_held", int'(bus.OnesOut), 9);
    drive(0, 1, 0);
    settle();
    check("cerr_carry", int'(bus.Carry), 1);
    check("cerr_tens", int'(bus.Tens), 1);

    // Clear priority over a 9->0 wrap, then re-prime with no event
    drive(0, 1, 8); drive(0, 1, 9);
    drive(1, 1, 0);
    settle();
    check_all_zero("clear");
    drive(0, 1, 9);
    settle();
    check("prime_borrow", int'(bus.Borrow), 0);
    check("prime_tens", int'(bus.Tens), 0);
    check("prime_onesout", int'(bus.OnesOut), 9);

    // Async reset between edges while Tens=5
    drive(1, 0, 0);
    drive(0, 1, 0);
    for (int i = 1; i <= 50; i++) drive(0, 1, i % 10);
    drive(0, 1, 1);
    settle();
    check("pre_reset_tens", int'(bus.Tens), 5);
    #1;
    Resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge Clock);
    Resetn = 1'b1;

    // Randomized phase: mostly +/-1 steps so wraps happen often
    last = 0;
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 99) < 3);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        o = 10 + int'($urandom_range(0, 5));
      end else begin
        case ($urandom_range(0, 2))
          0:       o = (last + 1) % 10;
          1:       o = (last + 9) % 10;
          default: o = last;
        endcase
        if (en) last = o;
      end
      drive(clr, en, o);
    end
    drive(0, 0, 0);
    settle();
    repeat (2) @(posedge Clock);
    #3;
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
